// File: rtl/booth_mul_arbiter.sv
// ============================================================================
// booth_mul_arbiter
// Round-robin scheduler sharing one 8x8 signed Booth multiplier among NREQ
// requesters, with a watchdog on the multiplier's done pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     ack,
  output logic [15:0]         rsp_prod,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                busy,
  output logic                mul_start,
  output logic [7:0]          mul_a,
  output logic [7:0]          mul_b,
  input  logic [15:0]         mul_prod,
  input  logic                mul_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [CW-1:0]   wait_cnt;

  logic            any_req;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  ptr_next;
  logic [IDW:0]    idx;

  // First set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!any_req && req[idx[IDW-1:0]]) begin
        any_req = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
    ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      wait_cnt  <= '0;
      ack       <= '0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            id        <= gnt_id;
            ptr       <= ptr_next;
            mul_a     <= req_a[8*gnt_id +: 8];
            mul_b     <= req_b[8*gnt_id +: 8];
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // wait_cnt counts completed WAIT cycles; the TIMEOUT-th gives up.
          if (mul_done) begin
            rsp_prod <= mul_prod;
            rsp_id   <= id;
            rsp_err  <= 1'b0;
            ack      <= NREQ'(1) << id;
            state    <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_prod <= '0;
            rsp_id   <= id;
            rsp_err  <= 1'b1;
            ack      <= NREQ'(1) << id;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          ack     <= '0;
          rsp_err <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
